match_event_log: RTL

Downstream consumer of the serial pattern detector's match output. Samples the detector's Mealy match strobe every clock, timestamps each match with a free-running bit index, and queues the timestamps in a small FIFO for a valid/ready consumer. Also keeps a saturating total-match count and a sticky overflow flag. One clock equals one serial input bit.

---
 rtl/detect_pkg.sv | 15 +
 rtl/event_fifo.sv | 83 ++++++++
 rtl/match_event_log.sv | 66 ++++++
 3 files changed

// File: rtl/detect_pkg.sv
// Shared constants and types for the serial pattern detector and its match-event logger.
package detect_pkg;

    localparam int DEF_IDX_W = 16;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_CNT_W = 8;

    typedef logic [DEF_IDX_W-1:0] bit_idx_t;

    // Width needed to hold an occupancy of 0..depth inclusive.
    function automatic int level_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous FIFO with a registered head word, occupancy output and synchronous clear.
module event_fifo
    import detect_pkg::*;
#(
    parameter int W     = DEF_IDX_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clr,
    input  logic                        push,
    input  logic                        pop,
    input  logic [W-1:0]                din,
    output logic [W-1:0]                head,
    output logic [level_w(DEPTH)-1:0]   level,
    output logic                        full,
    output logic                        empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = level_w(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;
    logic [LW-1:0] level_nxt;
    logic [W-1:0]  head_nxt;

    assign empty = (level == '0);
    assign full  = (level == LW'(DEPTH));

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        do_pop    = pop && !empty;
        do_push   = push && (!full || do_pop);
        level_nxt = level;
        head_nxt  = head;
        if (do_push && !do_pop)
            level_nxt = level + LW'(1);
        else if (do_pop && !do_push)
            level_nxt = level - LW'(1);
        // Head is kept in its own register so the output never comes from the RAM read mux.
        if (do_pop) begin
            if (level != LW'(1))
                head_nxt = mem[rd_ptr + PW'(1)];
            else if (do_push)
                head_nxt = din;
        end else if (empty && do_push) begin
            head_nxt = din;
        end
    end

    // NOTE: storage array has no reset; pointers and level alone define which words are valid.
    always_ff @(posedge clk) begin
        if (do_push && !clr)
            mem[wr_ptr] <= din;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            head   <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            head   <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            level <= level_nxt;
            head  <= head_nxt;
        end
    end

endmodule

// File: rtl/match_event_log.sv
// Timestamps each detector match with a free-running bit index and queues it for a consumer.
module match_event_log
    import detect_pkg::*;
#(
    parameter int IDX_W = DEF_IDX_W,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clr,
    input  logic                        z_in,
    output logic                        ev_valid,
    input  logic                        ev_ready,
    output logic [IDX_W-1:0]            ev_index,
    output logic [level_w(DEPTH)-1:0]   ev_level,
    output logic [CNT_W-1:0]            match_count,
    output logic                        overflow
);

    logic [IDX_W-1:0] bit_idx;
    logic             push;
    logic             full;
    logic             empty;
    logic             drop;

    assign push     = z_in && !clr;
    // Full implies a valid head, so a ready consumer always frees a slot for this match.
    assign drop     = push && full && !ev_ready;
    assign ev_valid = !empty;

    event_fifo #(
        .W     (IDX_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .push  (push),
        .pop   (ev_ready),
        .din   (bit_idx),
        .head  (ev_index),
        .level (ev_level),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_idx     <= '0;
            match_count <= '0;
            overflow    <= 1'b0;
        end else if (clr) begin
            bit_idx     <= '0;
            match_count <= '0;
            overflow    <= 1'b0;
        end else begin
            bit_idx <= bit_idx + IDX_W'(1);
            if (push && (match_count != '1))
                match_count <= match_count + CNT_W'(1);
            if (drop)
                overflow <= 1'b1;
        end
    end

endmodule
